// File: rtl/sysreg_spr_pkg.sv
// Shared encodings for the SPR update controller: execute-unit stack commands
// and the controller's FSM states.
package sysreg_spr_pkg;

  typedef enum logic [1:0] {
    SPR_CMD_WRITE = 2'b00,
    SPR_CMD_PUSH  = 2'b01,
    SPR_CMD_POP   = 2'b10,
    SPR_CMD_ADD   = 2'b11
  } spr_cmd_e;

  typedef enum logic [1:0] {
    SPR_ST_IDLE   = 2'd0,
    SPR_ST_ENTRY  = 2'd1,
    SPR_ST_RETURN = 2'd2
  } spr_state_e;

endpackage

// File: rtl/sysreg_spr_update_alu.sv
// Combinational base selection (forwarding the pending write), next-SPR arithmetic
// and optional stack-limit comparison (SYSREG_SPR_LIMIT_CHECK_EN).
module sysreg_spr_update_alu
  import sysreg_spr_pkg::*;
#(
  parameter int N          = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic         i_regist_req,
  input  logic [N-1:0] i_regist_data,
  input  logic [N-1:0] i_spr_info,
  input  logic [1:0]   i_cmd,
  input  logic [N-1:0] i_data,
  input  logic [N-1:0] i_limit_low,
  input  logic [N-1:0] i_limit_high,
  output logic [N-1:0] o_base,
  output logic [N-1:0] o_next,
  output logic         o_out_of_range
);

  localparam logic [N-1:0] LP_STEP = N'(WORD_BYTES);

  always_comb begin
    o_base = i_regist_req ? i_regist_data : i_spr_info;
    o_next = o_base;
    case (i_cmd)
      SPR_CMD_WRITE: o_next = i_data;
      SPR_CMD_PUSH:  o_next = o_base - LP_STEP;
      SPR_CMD_POP:   o_next = o_base + LP_STEP;
      // The offset is already N bits wide, so sign extension is the identity here.
      SPR_CMD_ADD:   o_next = o_base + i_data;
      default:       o_next = o_base;
    endcase
  end

`ifdef SYSREG_SPR_LIMIT_CHECK_EN
  assign o_out_of_range = (i_cmd != SPR_CMD_WRITE) &&
                          ((o_next < i_limit_low) || (o_next > i_limit_high));
`else
  logic w_unused_limits;
  assign w_unused_limits = ^{i_limit_low, i_limit_high};
  assign o_out_of_range  = 1'b0;
`endif

endmodule

// File: rtl/sysreg_spr_update.sv
// SPR update controller: turns stack commands and interrupt entry/return into a
// single-cycle SPR write, with a one-deep user SPR shadow. Option: SYSREG_SPR_LIMIT_CHECK_EN.
module sysreg_spr_update
  import sysreg_spr_pkg::*;
#(
  parameter int N          = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic         iCLOCK,
  input  logic         inRESET,
  input  logic         iRESET_SYNC,
  input  logic         iEXE_VALID,
  input  logic [1:0]   iEXE_CMD,
  input  logic [N-1:0] iEXE_DATA,
  output logic         oEXE_BUSY,
  input  logic         iIRQ_ENTRY,
  input  logic [N-1:0] iIRQ_KERNEL_SP,
  input  logic         iIRQ_RETURN,
  input  logic [N-1:0] iLIMIT_LOW,
  input  logic [N-1:0] iLIMIT_HIGH,
  input  logic [N-1:0] iSPR_INFO_DATA,
  output logic         oREGIST_REQ,
  output logic [N-1:0] oREGIST_DATA,
  output logic         oSHADOW_VALID,
  output logic         oIRQ_NEST,
  output logic         oFAULT,
  output logic [1:0]   oDEBUG_STATE
);

  spr_state_e   r_state, w_state_next;
  logic         r_shadow_valid;
  logic [N-1:0] r_shadow;
  logic         r_req, r_nest, r_fault;
  logic [N-1:0] r_data;
  logic [N-1:0] w_base, w_next;
  logic         w_out_of_range, w_idle, w_fsm_req;
  logic         w_entry_ok, w_ret_ok, w_nest, w_cmd_ok;

  sysreg_spr_update_alu #(.N(N), .WORD_BYTES(WORD_BYTES)) u_alu (
    .i_regist_req   (oREGIST_REQ),
    .i_regist_data  (oREGIST_DATA),
    .i_spr_info     (iSPR_INFO_DATA),
    .i_cmd          (iEXE_CMD),
    .i_data         (iEXE_DATA),
    .i_limit_low    (iLIMIT_LOW),
    .i_limit_high   (iLIMIT_HIGH),
    .o_base         (w_base),
    .o_next         (w_next),
    .o_out_of_range (w_out_of_range)
  );

  // Handshake: a command is consumed on any edge where iEXE_VALID=1 and oEXE_BUSY=0
  // (and no flush); while busy the execute unit must hold the command.
  assign w_idle     = (r_state == SPR_ST_IDLE) && !iRESET_SYNC;
  assign w_entry_ok = w_idle && iIRQ_ENTRY && !r_shadow_valid;
  assign w_nest     = w_idle && iIRQ_ENTRY && r_shadow_valid;
  assign w_ret_ok   = w_idle && !w_entry_ok && iIRQ_RETURN && r_shadow_valid;
  assign w_cmd_ok   = w_idle && !w_entry_ok && !w_ret_ok && iEXE_VALID;
  assign oEXE_BUSY  = (r_state != SPR_ST_IDLE) || w_entry_ok || w_ret_ok;

  // Entry/return writes are driven from the state so a same-cycle flush can kill them.
  assign w_fsm_req   = (r_state != SPR_ST_IDLE) && !iRESET_SYNC;
  assign oREGIST_REQ = r_req || w_fsm_req;

  always_comb begin
    oREGIST_DATA = r_data;
    case (r_state)
      SPR_ST_ENTRY:  oREGIST_DATA = iIRQ_KERNEL_SP;
      SPR_ST_RETURN: oREGIST_DATA = r_shadow;
      default:       oREGIST_DATA = r_data;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SPR_ST_IDLE: begin
        if (w_entry_ok)    w_state_next = SPR_ST_ENTRY;
        else if (w_ret_ok) w_state_next = SPR_ST_RETURN;
      end
      default: w_state_next = SPR_ST_IDLE;
    endcase
    if (iRESET_SYNC) w_state_next = SPR_ST_IDLE;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_state        <= SPR_ST_IDLE;
      r_shadow_valid <= 1'b0;
      r_shadow       <= '0;
      r_req          <= 1'b0;
      r_data         <= '0;
      r_nest         <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_req   <= w_cmd_ok && !w_out_of_range;
      r_fault <= w_cmd_ok && w_out_of_range;
      r_nest  <= w_nest;
      if (w_cmd_ok && !w_out_of_range) r_data <= w_next;
      if (w_entry_ok) r_shadow <= w_base;
      if (iRESET_SYNC)                     r_shadow_valid <= 1'b0;
      else if (w_entry_ok)                 r_shadow_valid <= 1'b1;
      else if (r_state == SPR_ST_RETURN)   r_shadow_valid <= 1'b0;
    end
  end

  assign oSHADOW_VALID = r_shadow_valid;
  assign oIRQ_NEST     = r_nest;
  assign oFAULT        = r_fault;
  assign oDEBUG_STATE  = r_state;

endmodule

// File: tb/tb_sysreg_spr_update.sv
// Self-checking bench for sysreg_spr_update: directed scenarios then random traffic,
// checked every cycle against a cycle-level stack-pointer reference model.
module tb_sysreg_spr_update;
  import sysreg_spr_pkg::*;

  localparam int N  = 32;
  localparam int WB = 4;

  logic         iCLOCK = 1'b0;
  logic         inRESET, iRESET_SYNC, iEXE_VALID, iIRQ_ENTRY, iIRQ_RETURN;
  logic [1:0]   iEXE_CMD;
  logic [N-1:0] iEXE_DATA, iIRQ_KERNEL_SP, iLIMIT_LOW, iLIMIT_HIGH, iSPR_INFO_DATA;
  logic         oEXE_BUSY, oREGIST_REQ, oSHADOW_VALID, oIRQ_NEST, oFAULT;
  logic [N-1:0] oREGIST_DATA;
  logic [1:0]   oDEBUG_STATE;

  sysreg_spr_update #(.N(N), .WORD_BYTES(WB)) dut (
    .iCLOCK         (iCLOCK),
    .inRESET        (inRESET),
    .iRESET_SYNC    (iRESET_SYNC),
    .iEXE_VALID     (iEXE_VALID),
    .iEXE_CMD       (iEXE_CMD),
    .iEXE_DATA      (iEXE_DATA),
    .oEXE_BUSY      (oEXE_BUSY),
    .iIRQ_ENTRY     (iIRQ_ENTRY),
    .iIRQ_KERNEL_SP (iIRQ_KERNEL_SP),
    .iIRQ_RETURN    (iIRQ_RETURN),
    .iLIMIT_LOW     (iLIMIT_LOW),
    .iLIMIT_HIGH    (iLIMIT_HIGH),
    .iSPR_INFO_DATA (iSPR_INFO_DATA),
    .oREGIST_REQ    (oREGIST_REQ),
    .oREGIST_DATA   (oREGIST_DATA),
    .oSHADOW_VALID  (oSHADOW_VALID),
    .oIRQ_NEST      (oIRQ_NEST),
    .oFAULT         (oFAULT),
    .oDEBUG_STATE   (oDEBUG_STATE)
  );

  // clock / reset
  always #5 iCLOCK = ~iCLOCK;

  int checks = 0;
  int errors = 0;

  // reference model: architected SP, shadow, pending interrupt write, registered pulses
  logic [N-1:0] m_sp, m_shadow, m_data, spr_env;
  logic         m_sv, m_req, m_nest, m_fault;
  int           m_pend;  // 0 none, 1 kernel SP write due, 2 shadow restore due
  logic [N-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    iRESET_SYNC = 1'b0; iEXE_VALID = 1'b0; iEXE_CMD = 2'b00; iEXE_DATA = '0;
    iIRQ_ENTRY = 1'b0; iIRQ_RETURN = 1'b0;
  endtask

  task automatic set_spr(input logic [N-1:0] v);
    m_sp = v; spr_env = v; iSPR_INFO_DATA = v;
  endtask

  // One clock: check current outputs against the model, then advance the model.
  task automatic cycle();
    logic         e_req, e_busy, ent_ok, ret_ok, bad;
    logic [N-1:0] e_data, nv, w;
    longint       sum;
    @(negedge iCLOCK);
    ent_ok = (m_pend == 0) && !iRESET_SYNC && iIRQ_ENTRY && !m_sv;
    ret_ok = (m_pend == 0) && !iRESET_SYNC && !ent_ok && iIRQ_RETURN && m_sv;
    e_busy = (m_pend != 0) || ent_ok || ret_ok;
    if (m_pend != 0) begin
      e_req  = !iRESET_SYNC;
      e_data = (m_pend == 1) ? iIRQ_KERNEL_SP : m_shadow;
    end else begin
      e_req  = m_req;
      e_data = m_data;
    end
    chk("req", oREGIST_REQ, e_req);
    chk("busy", oEXE_BUSY, e_busy);
    chk("shadow_valid", oSHADOW_VALID, m_sv);
    chk("nest", oIRQ_NEST, m_nest);
    chk("fault", oFAULT, m_fault);
    if (e_req) begin
      exp_q.push_back(e_data);
      w = exp_q.pop_front();
      if (oREGIST_REQ === 1'b1) chk("data", oREGIST_DATA, w);
    end
    @(posedge iCLOCK);
    if (e_req) spr_env = e_data;
    if (iRESET_SYNC) begin
      m_pend = 0; m_sv = 1'b0; m_req = 1'b0; m_nest = 1'b0; m_fault = 1'b0;
      m_sp = spr_env;
    end else begin
      m_req = 1'b0; m_nest = 1'b0; m_fault = 1'b0;
      if (m_pend == 1) begin
        m_sp = iIRQ_KERNEL_SP; m_pend = 0;
      end else if (m_pend == 2) begin
        m_sp = m_shadow; m_sv = 1'b0; m_pend = 0;
      end else begin
        m_nest = iIRQ_ENTRY && m_sv;
        if (ent_ok) begin
          m_shadow = m_sp; m_sv = 1'b1; m_pend = 1;
        end else if (ret_ok) begin
          m_pend = 2;
        end else if (iEXE_VALID) begin
          case (iEXE_CMD)
            2'b00:   sum = longint'(iEXE_DATA);
            2'b01:   sum = longint'(m_sp) - WB;
            2'b10:   sum = longint'(m_sp) + WB;
            default: sum = longint'(m_sp) + longint'($signed(iEXE_DATA));
          endcase
          nv = sum[N-1:0];
`ifdef SYSREG_SPR_LIMIT_CHECK_EN
          bad = (iEXE_CMD != 2'b00) && ((nv < iLIMIT_LOW) || (nv > iLIMIT_HIGH));
`else
          bad = 1'b0;
`endif
          if (bad) m_fault = 1'b1;
          else begin m_sp = nv; m_req = 1'b1; m_data = nv; end
        end
      end
    end
    #1 iSPR_INFO_DATA = spr_env;
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [N-1:0] d);
    iEXE_VALID = 1'b1; iEXE_CMD = c; iEXE_DATA = d;
    cycle();
    iEXE_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    clr();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int r;
    // reset
    inRESET = 1'b0; clr();
    iIRQ_KERNEL_SP = '0; iLIMIT_LOW = '0; iLIMIT_HIGH = '1;
    m_sp = '0; m_shadow = '0; m_data = '0; spr_env = '0; iSPR_INFO_DATA = '0;
    m_sv = 1'b0; m_req = 1'b0; m_nest = 1'b0; m_fault = 1'b0; m_pend = 0;
    repeat (2) @(posedge iCLOCK);
    #1;
    chk("rst_req", oREGIST_REQ, 1'b0);
    chk("rst_data", oREGIST_DATA, '0);
    chk("rst_busy", oEXE_BUSY, 1'b0);
    chk("rst_sv", oSHADOW_VALID, 1'b0);
    chk("rst_nest", oIRQ_NEST, 1'b0);
    chk("rst_fault", oFAULT, 1'b0);
    chk("rst_state", oDEBUG_STATE, SPR_ST_IDLE);
    @(negedge iCLOCK); inRESET = 1'b1;
    @(posedge iCLOCK); #1;

    // back-to-back push, push, pop with forwarding
    set_spr(32'h1000);
    do_cmd(2'b01, '0); chk("t1_push1", oREGIST_DATA, 32'h0FFC);
    do_cmd(2'b01, '0); chk("t1_push2", oREGIST_DATA, 32'h0FF8);
    do_cmd(2'b10, '0); chk("t1_pop", oREGIST_DATA, 32'h0FFC);
    chk("t1_req", oREGIST_REQ, 1'b1);
    idle(2);

    // signed add wraps below zero
    set_spr(32'h0);
    do_cmd(2'b11, 32'hFFFF_FFF0); chk("t2_wrap", oREGIST_DATA, 32'hFFFF_FFF0);
    idle(2);

    // interrupt entry and return
    set_spr(32'h2000);
    iIRQ_KERNEL_SP = 32'h8000; iIRQ_ENTRY = 1'b1; cycle(); iIRQ_ENTRY = 1'b0;
    chk("t3_ent_req", oREGIST_REQ, 1'b1);
    chk("t3_ent_data", oREGIST_DATA, 32'h8000);
    chk("t3_ent_busy", oEXE_BUSY, 1'b1);
    chk("t3_ent_sv", oSHADOW_VALID, 1'b1);
    idle(2);
    // nested entry is rejected
    iIRQ_KERNEL_SP = 32'h9000; iIRQ_ENTRY = 1'b1; cycle(); iIRQ_ENTRY = 1'b0;
    chk("t4_nest", oIRQ_NEST, 1'b1);
    chk("t4_nowrite", oREGIST_REQ, 1'b0);
    cycle(); chk("t4_nest_end", oIRQ_NEST, 1'b0);
    iIRQ_RETURN = 1'b1; cycle(); iIRQ_RETURN = 1'b0;
    chk("t3_ret_req", oREGIST_REQ, 1'b1);
    chk("t3_ret_data", oREGIST_DATA, 32'h2000);
    cycle(); chk("t3_ret_sv", oSHADOW_VALID, 1'b0);
    idle(1);

    // stack limit
    iLIMIT_LOW = 32'h100; iLIMIT_HIGH = 32'hFFF;
    set_spr(32'h100);
    do_cmd(2'b01, '0);
`ifdef SYSREG_SPR_LIMIT_CHECK_EN
    chk("t5_fault", oFAULT, 1'b1);
    chk("t5_nowrite", oREGIST_REQ, 1'b0);
    do_cmd(2'b10, '0); chk("t5_pop", oREGIST_DATA, 32'h104);
`else
    chk("t5_nofault", oFAULT, 1'b0);
    chk("t5_push", oREGIST_DATA, 32'h0FC);
    do_cmd(2'b10, '0); chk("t5_pop", oREGIST_DATA, 32'h100);
`endif
    idle(2);

    // flush while the kernel SP write is due
    iLIMIT_LOW = '0; iLIMIT_HIGH = '1;
    set_spr(32'h3000);
    iIRQ_KERNEL_SP = 32'h9000; iIRQ_ENTRY = 1'b1; cycle(); iIRQ_ENTRY = 1'b0;
    iRESET_SYNC = 1'b1; cycle(); iRESET_SYNC = 1'b0;
    chk("t6_state", oDEBUG_STATE, SPR_ST_IDLE);
    chk("t6_sv", oSHADOW_VALID, 1'b0);
    chk("t6_req", oREGIST_REQ, 1'b0);
    idle(2);

    // random traffic
    iLIMIT_LOW = 32'h1000; iLIMIT_HIGH = 32'hF000;
    set_spr(32'h8000);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      iRESET_SYNC    = (r < 2);
      iIRQ_ENTRY     = (r >= 2 && r < 7);
      iIRQ_RETURN    = (r >= 7 && r < 13);
      iIRQ_KERNEL_SP = 32'($urandom_range(32'h1000, 32'hF000));
      iEXE_VALID     = ($urandom_range(0, 3) != 0);
      iEXE_CMD       = 2'($urandom_range(0, 3));
      if (iEXE_CMD == 2'b00) iEXE_DATA = 32'($urandom_range(32'h0800, 32'hF800));
      else                   iEXE_DATA = 32'($urandom_range(0, 512)) - 32'd256;
      cycle();
    end
    idle(3);
    chk("exp_q_empty", 32'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysreg_spr_update.md
# sysreg_spr_update

Update controller sitting directly upstream of the SPR (stack pointer) system register in the execute stage. It turns execute-unit stack commands (direct write, push, pop, signed add) and interrupt entry/return events into the single-cycle write request (`oREGIST_REQ`/`oREGIST_DATA`) that the SPR register consumes. It reads the SPR value back from the register's info output and forwards its own pending write so back-to-back updates never see stale data. It also keeps a one-deep shadow of the user SPR across interrupts.

## Interface
- N, 32, SPR width in bits
- WORD_BYTES, 4, push/pop step in bytes (must be less than 2^N)

- iCLOCK  in  1  clock
- inRESET  in  1  reset: asynchronous, active-low
- iRESET_SYNC  in  1  synchronous flush (pipeline flush / soft reset)
- iEXE_VALID  in  1  execute command valid
- iEXE_CMD  in  2  00 write, 01 push, 10 pop, 11 add
- iEXE_DATA  in  N  write value (cmd 00) or signed offset (cmd 11); ignored otherwise
- oEXE_BUSY  out  1  command not accepted this cycle
- iIRQ_ENTRY  in  1  interrupt entry pulse
- iIRQ_KERNEL_SP  in  N  kernel SPR loaded on entry
- iIRQ_RETURN  in  1  interrupt return pulse
- iLIMIT_LOW  in  N  lowest legal SPR, unsigned, inclusive
- iLIMIT_HIGH  in  N  highest legal SPR, unsigned, inclusive
- iSPR_INFO_DATA  in  N  current SPR, from the SPR register
- oREGIST_REQ  out  1  SPR write strobe
- oREGIST_DATA  out  N  SPR write value
- oSHADOW_VALID  out  1  user SPR saved (inside interrupt)
- oIRQ_NEST  out  1  one-cycle pulse: entry rejected because the shadow is occupied
- oFAULT  out  1  one-cycle pulse: stack-limit violation, write suppressed

## Operation
- Base value: `oREGIST_DATA` if `oREGIST_REQ` is 1 this cycle, else `iSPR_INFO_DATA`.
- Arithmetic is modulo 2^N and unsigned wrap-around is permitted:
  - push: base − WORD_BYTES
  - pop: base + WORD_BYTES
  - add: base + sign-extended `iEXE_DATA`
  - write: `iEXE_DATA`
- FSM states:
  - IDLE
  - ENTRY: emits the kernel SP write
  - RETURN: emits the shadow restore
- Priority within IDLE: iRESET_SYNC > iIRQ_ENTRY > iIRQ_RETURN > execute command.
- IDLE + iIRQ_ENTRY with shadow empty:
  - shadow ← base, shadow valid ← 1, go to ENTRY.
  - In ENTRY: `oREGIST_REQ`=1 with `iIRQ_KERNEL_SP`, then back to IDLE.
- IDLE + iIRQ_ENTRY with shadow valid: `oIRQ_NEST` pulses; no state change; the command is dropped.
- IDLE + iIRQ_RETURN with shadow valid:
  - Go to RETURN.
  - In RETURN: `oREGIST_REQ`=1 with the shadow value, shadow valid ← 0, then back to IDLE.
- IDLE + iIRQ_RETURN with shadow empty: ignored.
- `oEXE_BUSY`=1 in these cases; a command presented while busy is not consumed and the execute unit holds it:
  - in ENTRY or RETURN;
  - in IDLE when iIRQ_ENTRY or iIRQ_RETURN is accepted the same cycle.
- iRESET_SYNC has the same effect as reset, in any state and on that clock edge:
  - state → IDLE, shadow valid → 0, `oREGIST_REQ` → 0;
  - any accepted-but-unwritten update is dropped.
- Reset values: `oREGIST_REQ` 0, `oREGIST_DATA` 0, `oEXE_BUSY` 0, `oSHADOW_VALID` 0, `oIRQ_NEST` 0, `oFAULT` 0, shadow 0, state IDLE.

## Timing
- Execute command accepted at edge T produces `oREGIST_REQ`/`oREGIST_DATA` registered for cycle T+1; the SPR register holds the value from T+2.
- Back-to-back commands are supported at 1 per cycle; forwarding the base guarantees correct accumulation.
- iIRQ_ENTRY accepted at T:
  - shadow captured at T;
  - `oREGIST_REQ` (kernel SP) in cycle T+1;
  - `oEXE_BUSY` high during T and T+1.
- iIRQ_RETURN is symmetric to entry.
- `oREGIST_REQ` is never high for two consecutive unrelated updates without new acceptance; it is a single-cycle pulse per update.

## Configuration
- Macro: `SYSREG_SPR_LIMIT_CHECK_EN`.
- Defined:
  - push, pop and add results outside [iLIMIT_LOW, iLIMIT_HIGH] are suppressed: no `oREGIST_REQ`;
  - `oFAULT` pulses in the cycle the write would have appeared;
  - the forwarded base stays unchanged.
- Defined: write (cmd 00), entry and return are never checked.
- Undefined: limit ports are ignored, `oFAULT` is tied 0, and every accepted command writes.

## Structure
- Shared package `sysreg_spr_pkg` holds:
  - command encodings `SPR_CMD_WRITE/PUSH/POP/ADD`;
  - FSM state encodings `SPR_ST_IDLE/ENTRY/RETURN`.
- One sub-module, `sysreg_spr_update_alu`: combinational base selection, next-value arithmetic and limit comparison.
- The FSM and the shadow register live in the top module.

## Test plan
- Reset, then SPR=0x1000 (iSPR_INFO_DATA), then push, push, pop on consecutive cycles → `oREGIST_DATA` 0x0FFC, 0x0FF8, 0x0FFC in consecutive cycles, each with `oREGIST_REQ`=1.
- Add with `iEXE_DATA`=0xFFFFFFF0 on SPR 0x0 → `oREGIST_DATA`=0xFFFFFFF0 (wrap); limit check off.
- SPR=0x2000, iIRQ_ENTRY with kernel SP 0x8000 → next cycle write 0x8000, `oSHADOW_VALID`=1, `oEXE_BUSY` high two cycles. Then iIRQ_RETURN → write 0x2000, `oSHADOW_VALID`=0.
- Second iIRQ_ENTRY while the shadow is valid → `oIRQ_NEST` one-cycle pulse; no write; shadow still 0x2000.
- With `SYSREG_SPR_LIMIT_CHECK_EN`, limits [0x100, 0xFFF], SPR=0x100, push → `oFAULT` pulse, no write. A following pop forwards from 0x100 and writes 0x104.
- iRESET_SYNC asserted in the cycle after an entry is accepted (state ENTRY) → no kernel SP write, state IDLE, `oSHADOW_VALID`=0.
